// File: rtl/spi_talker.sv
// Transmit framer feeding 24-bit words, MSB byte first, to the SPI slave shifter.
// Define SPI_TALKER_FIFO_EN to replace the single holding register with a frame FIFO.
module spi_talker #(
   parameter logic [7:0] first_byte = 8'h20,
   parameter logic [7:0] IDLE_BYTE  = 8'h00,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic        spi_slave_tx_req,
   output logic [7:0]  spi_slave_tx_byte,
   output logic        spi_slave_tx_load,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, SENT0, SENT1} state_t;

   state_t      state;
   logic [23:0] shift_reg;
   logic [23:0] framed;
   logic [23:0] buf_head;
   logic        buf_empty;
   logic        full_next;
   logic        push;
   logic        pop;

   // The header bits are forced on entry so the far-end listener can find frame boundaries.
   assign framed = {first_byte[7:5], tx_data[20:0]};
   assign push   = tx_valid && tx_ready;
   assign pop    = spi_slave_tx_req && (state == IDLE) && !buf_empty;

`ifdef SPI_TALKER_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [23:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] wr_next;
   logic [AW:0] rd_next;

   assign wr_next   = push ? wr_ptr + PTR_ONE : wr_ptr;
   assign rd_next   = pop  ? rd_ptr + PTR_ONE : rd_ptr;
   assign buf_empty = (wr_ptr == rd_ptr);
   assign buf_head  = mem[rd_ptr[AW-1:0]];
   assign full_next = (wr_next[AW] != rd_next[AW]) &&
                      (wr_next[AW-1:0] == rd_next[AW-1:0]);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= framed;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
      end
   end
`else
   logic        hold_valid;
   logic [23:0] hold_data;

   assign buf_empty = !hold_valid;
   assign buf_head  = hold_data;
   assign full_next = push ? 1'b1 : (pop ? 1'b0 : hold_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else begin
         hold_valid <= full_next;
         if (push) hold_data <= framed;
      end
   end
`endif

   // Ready tracks next-cycle occupancy, so a pop never frees room for a same-cycle push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_ready <= 1'b0;
      else        tx_ready <= !full_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         shift_reg         <= '0;
         spi_slave_tx_byte <= IDLE_BYTE;
         spi_slave_tx_load <= 1'b0;
         frame_done        <= 1'b0;
      end else begin
         spi_slave_tx_load <= 1'b0;
         frame_done        <= 1'b0;
         if (spi_slave_tx_req) begin
            spi_slave_tx_load <= 1'b1;
            case (state)
               IDLE: begin
                  if (pop) begin
                     shift_reg         <= buf_head;
                     spi_slave_tx_byte <= buf_head[23:16];
                     state             <= SENT0;
                  end else begin
                     spi_slave_tx_byte <= IDLE_BYTE;
                  end
               end
               SENT0: begin
                  spi_slave_tx_byte <= shift_reg[15:8];
                  state             <= SENT1;
               end
               SENT1: begin
                  spi_slave_tx_byte <= shift_reg[7:0];
                  frame_done        <= 1'b1;
                  state             <= IDLE;
               end
               default: begin
                  spi_slave_tx_byte <= IDLE_BYTE;
                  state             <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_talker.sv
// Directed bench for spi_talker; FIFO-specific steps follow SPI_TALKER_FIFO_EN.
module tb_spi_talker;

   logic        clk;
   logic        rst_n;
   logic [23:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        spi_slave_tx_req;
   logic [7:0]  spi_slave_tx_byte;
   logic        spi_slave_tx_load;
   logic        frame_done;

   int passed;
   int total;

   spi_talker #(
      .first_byte(8'h20),
      .IDLE_BYTE (8'h00),
      .FIFO_DEPTH(4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .spi_slave_tx_req (spi_slave_tx_req),
      .spi_slave_tx_byte(spi_slave_tx_byte),
      .spi_slave_tx_load(spi_slave_tx_load),
      .frame_done       (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // One request pulse, then checks of the load pulse and the byte it carries.
   task automatic apply_req(input string tag, input logic [7:0] exp_byte, input logic exp_done);
      @(negedge clk) spi_slave_tx_req = 1'b1;
      @(negedge clk) spi_slave_tx_req = 1'b0;
      check_output({tag, ".load"}, {31'd0, spi_slave_tx_load}, 32'd1);
      check_output({tag, ".byte"}, {24'd0, spi_slave_tx_byte}, {24'd0, exp_byte});
      check_output({tag, ".done"}, {31'd0, frame_done}, {31'd0, exp_done});
      @(negedge clk);
      check_output({tag, ".load_off"}, {31'd0, spi_slave_tx_load}, 32'd0);
      repeat (7) @(negedge clk);
   endtask

   task automatic apply_push(input string tag, input logic [23:0] d);
      @(negedge clk);
      check_output({tag, ".ready"}, {31'd0, tx_ready}, 32'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk) tx_valid = 1'b0;
   endtask

`ifdef SPI_TALKER_FIFO_EN
   logic [23:0] words6 [4];
   logic [7:0]  bytes6 [12];
`endif

   initial begin
      passed           = 0;
      total            = 0;
      rst_n            = 1'b0;
      tx_data          = '0;
      tx_valid         = 1'b0;
      spi_slave_tx_req = 1'b0;

      repeat (2) @(negedge clk);
      check_output("rst.ready", {31'd0, tx_ready}, 32'd0);
      check_output("rst.byte", {24'd0, spi_slave_tx_byte}, 32'h00);
      check_output("rst.load", {31'd0, spi_slave_tx_load}, 32'd0);
      check_output("rst.done", {31'd0, frame_done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("rst.ready_after", {31'd0, tx_ready}, 32'd1);

      $display("[TB] test 1: single frame");
      apply_push("t1.push", 24'hABCDEF);
`ifdef SPI_TALKER_FIFO_EN
      check_output("t1.ready_full", {31'd0, tx_ready}, 32'd1);
`else
      check_output("t1.ready_full", {31'd0, tx_ready}, 32'd0);
`endif
      apply_req("t1.b0", 8'h2B, 1'b0);
      apply_req("t1.b1", 8'hCD, 1'b0);
      apply_req("t1.b2", 8'hEF, 1'b1);
      check_output("t1.ready_back", {31'd0, tx_ready}, 32'd1);

      $display("[TB] test 2: idle filler");
      apply_req("t2.i0", 8'h00, 1'b0);
      apply_req("t2.i1", 8'h00, 1'b0);

      $display("[TB] test 3: back-pressure");
`ifdef SPI_TALKER_FIFO_EN
      apply_push("t3.push0", 24'h123456);
      check_output("t3.ready_mid", {31'd0, tx_ready}, 32'd1);
      apply_push("t3.push1", 24'h654321);
      apply_req("t3.a0", 8'h32, 1'b0);
`else
      @(negedge clk);
      check_output("t3.ready0", {31'd0, tx_ready}, 32'd1);
      tx_data  = 24'h123456;
      tx_valid = 1'b1;
      @(negedge clk) tx_data = 24'h654321;
      check_output("t3.ready_blocked", {31'd0, tx_ready}, 32'd0);
      repeat (5) @(negedge clk);
      check_output("t3.ready_held", {31'd0, tx_ready}, 32'd0);
      apply_req("t3.a0", 8'h32, 1'b0);
      tx_valid = 1'b0;
      check_output("t3.ready_refull", {31'd0, tx_ready}, 32'd0);
`endif
      apply_req("t3.a1", 8'h34, 1'b0);
      apply_req("t3.a2", 8'h56, 1'b1);
      apply_req("t3.b0", 8'h25, 1'b0);
      apply_req("t3.b1", 8'h43, 1'b0);
      apply_req("t3.b2", 8'h21, 1'b1);
      check_output("t3.ready_end", {31'd0, tx_ready}, 32'd1);

      $display("[TB] test 4: reset mid-frame");
      apply_push("t4.push", 24'h0F0F0F);
      @(negedge clk) spi_slave_tx_req = 1'b1;
      @(negedge clk) spi_slave_tx_req = 1'b0;
      check_output("t4.b0.load", {31'd0, spi_slave_tx_load}, 32'd1);
      check_output("t4.b0.byte", {24'd0, spi_slave_tx_byte}, 32'h2F);
      #1 rst_n = 1'b0;
      #1;
      check_output("t4.rst.byte", {24'd0, spi_slave_tx_byte}, 32'h00);
      check_output("t4.rst.load", {31'd0, spi_slave_tx_load}, 32'd0);
      check_output("t4.rst.ready", {31'd0, tx_ready}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check_output("t4.ready_after", {31'd0, tx_ready}, 32'd1);
      apply_req("t4.i0", 8'h00, 1'b0);
      apply_req("t4.i1", 8'h00, 1'b0);

      $display("[TB] test 5: push during idle request");
      @(negedge clk);
      tx_data          = 24'hC3B4A5;
      tx_valid         = 1'b1;
      spi_slave_tx_req = 1'b1;
      @(negedge clk);
      tx_valid         = 1'b0;
      spi_slave_tx_req = 1'b0;
      check_output("t5.i.load", {31'd0, spi_slave_tx_load}, 32'd1);
      check_output("t5.i.byte", {24'd0, spi_slave_tx_byte}, 32'h00);
      repeat (7) @(negedge clk);
      apply_req("t5.b0", 8'h23, 1'b0);
      apply_req("t5.b1", 8'hB4, 1'b0);
      apply_req("t5.b2", 8'hA5, 1'b1);

`ifdef SPI_TALKER_FIFO_EN
      $display("[TB] test 6: FIFO fill and wrap");
      words6 = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
      bytes6 = '{8'h21, 8'h02, 8'h03, 8'h24, 8'h05, 8'h06,
                 8'h27, 8'h08, 8'h09, 8'h2A, 8'h0B, 8'h0C};
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) apply_push($sformatf("t6.r%0d.push%0d", r, i), words6[i]);
         check_output($sformatf("t6.r%0d.full", r), {31'd0, tx_ready}, 32'd0);
         for (int j = 0; j < 12; j++)
            apply_req($sformatf("t6.r%0d.b%0d", r, j), bytes6[j], (j % 3) == 2);
         check_output($sformatf("t6.r%0d.ready", r), {31'd0, tx_ready}, 32'd1);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
